// File: rtl/fifo_sync_flags_pkg.sv
// Shared definitions for the fifo_sync_flags FIFO: mode constants,
// the per-cycle operation classification and small configuration helpers.
package fifo_sync_flags_pkg;

    // Request qualification modes
    localparam int EDGE_MODE_LEVEL = 0;
    localparam int EDGE_MODE_EDGE  = 1;

    // Read data presentation modes
    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    // What the storage does in a given cycle, encoded as {write, read}
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    // True when v is a positive power of two
    function automatic bit isPow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Width needed to hold a fill level from 0 up to and including depth
    function automatic int levelWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Host-facing bundle of the FIFO: request/data inputs from the producer and
// consumer side, data and status flags back from the FIFO.
interface fifo_sync_flags_if
    import fifo_sync_flags_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int LVL_W = levelWidth(DEPTH);

    logic                  write_en;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  clear_errors;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [LVL_W-1:0]      level;
    logic                  overflow;
    logic                  underflow;

    // The side that pushes and pops
    modport master (
        output write_en, read_en, data_in, clear_errors,
        input  data_out, data_valid, full, empty, almost_full,
               almost_empty, level, overflow, underflow
    );

    // The FIFO itself
    modport slave (
        input  write_en, read_en, data_in, clear_errors,
        output data_out, data_valid, full, empty, almost_full,
               almost_empty, level, overflow, underflow
    );

endinterface

// File: rtl/fifo_req_qual.sv
// Turns a raw enable into a request: either every rising edge of the enable
// (one operation per press) or the enable itself (one operation per cycle).
module fifo_req_qual
    import fifo_sync_flags_pkg::*;
#(
    parameter int EDGE_MODE = EDGE_MODE_EDGE
) (
    input  logic clock,
    input  logic reset,
    input  logic i_en,
    output logic o_req
);

    logic r_en_d;

    // Remember last cycle's enable; cleared on reset so an enable held
    // through reset still produces one request right after it
    always_ff @(posedge clock) begin
        if (reset) begin
            r_en_d <= 1'b0;
        end else begin
            r_en_d <= i_en;
        end
    end

    assign o_req = (EDGE_MODE == EDGE_MODE_EDGE) ? (i_en & ~r_en_d) : i_en;

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with edge/level request modes, first-word-fall-through or
// registered read data, push-while-full when a pop happens in the same cycle,
// threshold flags, fill level and sticky overflow/underflow flags.
module fifo_sync_flags
    import fifo_sync_flags_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int EDGE_MODE     = EDGE_MODE_EDGE,
    parameter int FWFT          = FWFT_ON,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input logic              clock,
    input logic              reset,
    fifo_sync_flags_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = levelWidth(DEPTH);

    // Bad geometry or thresholds are caught before anything runs
    if (!isPow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_flags: DEPTH=%0d must be a power of two >= 2", DEPTH);
    end
    if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("fifo_sync_flags: AFULL_THRESH=%0d outside 0..DEPTH", AFULL_THRESH);
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH) begin : g_bad_aempty
        $error("fifo_sync_flags: AEMPTY_THRESH=%0d outside 0..DEPTH", AEMPTY_THRESH);
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;

    logic                  w_wr_req;
    logic                  w_rd_req;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_full;
    logic                  w_empty;
    fifo_op_e              w_op;

    fifo_req_qual #(
        .EDGE_MODE (EDGE_MODE)
    ) u_wr_qual (
        .clock (clock),
        .reset (reset),
        .i_en  (bus.write_en),
        .o_req (w_wr_req)
    );

    fifo_req_qual #(
        .EDGE_MODE (EDGE_MODE)
    ) u_rd_qual (
        .clock (clock),
        .reset (reset),
        .i_en  (bus.read_en),
        .o_req (w_rd_req)
    );

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_W'(DEPTH));

    // A pop needs data; a push needs room, or a pop freeing a slot this cycle.
    // A pop on empty is refused even if a push arrives together with it.
    assign w_rd_acc = w_rd_req & ~w_empty;
    assign w_wr_acc = w_wr_req & (~w_full | w_rd_acc);

    // Classify the cycle so the level update reads as a simple table
    always_comb begin
        w_op = OP_IDLE;
        case ({w_wr_acc, w_rd_acc})
            2'b01:   w_op = OP_READ;
            2'b10:   w_op = OP_WRITE;
            2'b11:   w_op = OP_BOTH;
            default: w_op = OP_IDLE;
        endcase
    end

    // Storage array, deliberately not reset; only the pointers define contents
    always_ff @(posedge clock) begin
        if (!reset && w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    // Pointers and fill level; pointers wrap by plain binary overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case (w_op)
                OP_WRITE: r_level <= r_level + LVL_W'(1);
                OP_READ:  r_level <= r_level - LVL_W'(1);
                default:  r_level <= r_level;
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as a clear survives
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_req && !w_wr_acc) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_errors) begin
                r_overflow <= 1'b0;
            end
            if (w_rd_req && !w_rd_acc) begin
                r_underflow <= 1'b1;
            end else if (bus.clear_errors) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Registered read path: capture the head on a pop and pulse valid once
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    assign bus.data_out     = (FWFT == FWFT_ON) ? r_mem[r_rd_ptr] : r_data_out;
    assign bus.data_valid   = (FWFT == FWFT_ON) ? ~w_empty : r_data_valid;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_level >= LVL_W'(AFULL_THRESH));
    assign bus.almost_empty = (r_level <= LVL_W'(AEMPTY_THRESH));
    assign bus.level        = r_level;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Self-checking bench for fifo_sync_flags: four configurations side by side,
// directed scenarios plus randomized traffic against a queue-based model.
module tb_fifo_sync_flags;

    int checks   = 0;
    int failures = 0;

    logic clock = 1'b0;
    logic rst_e4, rst_l4, rst_r4, rst_d16;

    always #5 clock = ~clock;

    // e4: depth 4, edge requests, fall-through
    fifo_sync_flags_if #(.DATA_WIDTH(8), .DEPTH(4)) if_e4();
    fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(4), .EDGE_MODE(1), .FWFT(1),
                      .AFULL_THRESH(2), .AEMPTY_THRESH(2))
        u_e4 (.clock(clock), .reset(rst_e4), .bus(if_e4));

    // l4: depth 4, level requests, fall-through
    fifo_sync_flags_if #(.DATA_WIDTH(8), .DEPTH(4)) if_l4();
    fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(4), .EDGE_MODE(0), .FWFT(1),
                      .AFULL_THRESH(3), .AEMPTY_THRESH(1))
        u_l4 (.clock(clock), .reset(rst_l4), .bus(if_l4));

    // r4: depth 4, edge requests, registered read data
    fifo_sync_flags_if #(.DATA_WIDTH(8), .DEPTH(4)) if_r4();
    fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(4), .EDGE_MODE(1), .FWFT(0),
                      .AFULL_THRESH(3), .AEMPTY_THRESH(0))
        u_r4 (.clock(clock), .reset(rst_r4), .bus(if_r4));

    // d16: depth 16, level requests, fall-through
    fifo_sync_flags_if #(.DATA_WIDTH(8), .DEPTH(16)) if_d16();
    fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(16), .EDGE_MODE(0), .FWFT(1),
                      .AFULL_THRESH(14), .AEMPTY_THRESH(2))
        u_d16 (.clock(clock), .reset(rst_d16), .bus(if_d16));

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst_e4 = 1'b1; rst_l4 = 1'b1; rst_r4 = 1'b1; rst_d16 = 1'b1;
        tick();
        tick();
        rst_e4 = 1'b0; rst_l4 = 1'b0; rst_r4 = 1'b0; rst_d16 = 1'b0;
        // flags order: full empty almost_full almost_empty overflow underflow data_valid
        checks++; if ({if_e4.full, if_e4.empty, if_e4.almost_full, if_e4.almost_empty, if_e4.overflow, if_e4.underflow, if_e4.data_valid} !== 7'b0101000) begin failures++; $display("[TB] FAIL reset_flags_e4: got %b expected 0101000", {if_e4.full, if_e4.empty, if_e4.almost_full, if_e4.almost_empty, if_e4.overflow, if_e4.underflow, if_e4.data_valid}); end
        checks++; if ({if_l4.full, if_l4.empty, if_l4.almost_full, if_l4.almost_empty, if_l4.overflow, if_l4.underflow, if_l4.data_valid} !== 7'b0101000) begin failures++; $display("[TB] FAIL reset_flags_l4: got %b expected 0101000", {if_l4.full, if_l4.empty, if_l4.almost_full, if_l4.almost_empty, if_l4.overflow, if_l4.underflow, if_l4.data_valid}); end
        checks++; if ({if_r4.full, if_r4.empty, if_r4.almost_full, if_r4.almost_empty, if_r4.overflow, if_r4.underflow, if_r4.data_valid} !== 7'b0101000) begin failures++; $display("[TB] FAIL reset_flags_r4: got %b expected 0101000", {if_r4.full, if_r4.empty, if_r4.almost_full, if_r4.almost_empty, if_r4.overflow, if_r4.underflow, if_r4.data_valid}); end
        checks++; if ({if_d16.full, if_d16.empty, if_d16.almost_full, if_d16.almost_empty, if_d16.overflow, if_d16.underflow, if_d16.data_valid} !== 7'b0101000) begin failures++; $display("[TB] FAIL reset_flags_d16: got %b expected 0101000", {if_d16.full, if_d16.empty, if_d16.almost_full, if_d16.almost_empty, if_d16.overflow, if_d16.underflow, if_d16.data_valid}); end
        checks++; if (if_e4.level !== 3'd0 || if_d16.level !== 5'd0) begin failures++; $display("[TB] FAIL reset_level: got e4=%0d d16=%0d expected 0", if_e4.level, if_d16.level); end
        checks++; if (if_r4.data_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_dout_r4: got %h expected 00", if_r4.data_out); end
    endtask

    // Five pulsed pushes into a depth-4 edge FIFO, then drain
    task automatic test_overflow_edge();
        for (int i = 0; i < 5; i++) begin
            if_e4.data_in = 8'hA1 + 8'(i);
            if_e4.write_en = 1'b1;
            tick();
            if_e4.write_en = 1'b0;
            tick();
        end
        checks++; if (if_e4.full !== 1'b1 || if_e4.level !== 3'd4) begin failures++; $display("[TB] FAIL t1_full: got full=%b level=%0d expected full=1 level=4", if_e4.full, if_e4.level); end
        checks++; if (if_e4.overflow !== 1'b1) begin failures++; $display("[TB] FAIL t1_overflow: got %b expected 1", if_e4.overflow); end
        checks++; if (if_e4.data_out !== 8'hA1) begin failures++; $display("[TB] FAIL t1_head: got %h expected a1", if_e4.data_out); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (if_e4.data_out !== 8'hA1 + 8'(i)) begin failures++; $display("[TB] FAIL t1_pop%0d: got %h expected %h", i, if_e4.data_out, 8'hA1 + 8'(i)); end
            if_e4.read_en = 1'b1;
            tick();
            if_e4.read_en = 1'b0;
            tick();
        end
        checks++; if (if_e4.empty !== 1'b1 || if_e4.overflow !== 1'b1 || if_e4.underflow !== 1'b0) begin failures++; $display("[TB] FAIL t1_drained: got empty=%b ovf=%b unf=%b expected 1 1 0", if_e4.empty, if_e4.overflow, if_e4.underflow); end
        if_e4.clear_errors = 1'b1;
        tick();
        if_e4.clear_errors = 1'b0;
        checks++; if (if_e4.overflow !== 1'b0) begin failures++; $display("[TB] FAIL t1_clear: got %b expected 0", if_e4.overflow); end
    endtask

    // A held enable in edge mode is a single push
    task automatic test_edge_hold();
        if_e4.data_in = 8'h55;
        if_e4.write_en = 1'b1;
        repeat (5) tick();
        if_e4.write_en = 1'b0;
        tick();
        checks++; if (if_e4.level !== 3'd1 || if_e4.overflow !== 1'b0) begin failures++; $display("[TB] FAIL t2_hold: got level=%0d ovf=%b expected 1 0", if_e4.level, if_e4.overflow); end
        checks++; if (if_e4.data_out !== 8'h55) begin failures++; $display("[TB] FAIL t2_data: got %h expected 55", if_e4.data_out); end
        if_e4.read_en = 1'b1;
        tick();
        if_e4.read_en = 1'b0;
        tick();
        checks++; if (if_e4.empty !== 1'b1) begin failures++; $display("[TB] FAIL t2_empty: got %b expected 1", if_e4.empty); end
    endtask

    // Push and pop together while full keeps the level and loses nothing
    task automatic test_push_pop_full();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h32; exp_seq[1] = 8'h33; exp_seq[2] = 8'h34; exp_seq[3] = 8'h77;
        if_l4.write_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_l4.data_in = 8'h31 + 8'(i);
            tick();
        end
        if_l4.write_en = 1'b0;
        checks++; if (if_l4.full !== 1'b1 || if_l4.level !== 3'd4) begin failures++; $display("[TB] FAIL t3_fill: got full=%b level=%0d expected 1 4", if_l4.full, if_l4.level); end
        if_l4.data_in = 8'h77;
        if_l4.write_en = 1'b1;
        if_l4.read_en = 1'b1;
        tick();
        if_l4.write_en = 1'b0;
        if_l4.read_en = 1'b0;
        checks++; if (if_l4.level !== 3'd4 || if_l4.overflow !== 1'b0 || if_l4.underflow !== 1'b0) begin failures++; $display("[TB] FAIL t3_both: got level=%0d ovf=%b unf=%b expected 4 0 0", if_l4.level, if_l4.overflow, if_l4.underflow); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (if_l4.data_out !== exp_seq[i]) begin failures++; $display("[TB] FAIL t3_pop%0d: got %h expected %h", i, if_l4.data_out, exp_seq[i]); end
            if_l4.read_en = 1'b1;
            tick();
        end
        if_l4.read_en = 1'b0;
        checks++; if (if_l4.empty !== 1'b1 || if_l4.underflow !== 1'b0) begin failures++; $display("[TB] FAIL t3_drained: got empty=%b unf=%b expected 1 0", if_l4.empty, if_l4.underflow); end
    endtask

    // Push and pop together while empty: pop refused, push kept
    task automatic test_push_pop_empty();
        if_l4.data_in = 8'h3C;
        if_l4.write_en = 1'b1;
        if_l4.read_en = 1'b1;
        tick();
        if_l4.write_en = 1'b0;
        if_l4.read_en = 1'b0;
        checks++; if (if_l4.underflow !== 1'b1 || if_l4.level !== 3'd1) begin failures++; $display("[TB] FAIL t4_underflow: got unf=%b level=%0d expected 1 1", if_l4.underflow, if_l4.level); end
        checks++; if (if_l4.data_out !== 8'h3C || if_l4.data_valid !== 1'b1) begin failures++; $display("[TB] FAIL t4_head: got %h valid=%b expected 3c 1", if_l4.data_out, if_l4.data_valid); end
        if_l4.read_en = 1'b1;
        tick();
        if_l4.read_en = 1'b0;
        checks++; if (if_l4.empty !== 1'b1 || if_l4.underflow !== 1'b1) begin failures++; $display("[TB] FAIL t4_after: got empty=%b unf=%b expected 1 1", if_l4.empty, if_l4.underflow); end
        if_l4.clear_errors = 1'b1;
        tick();
        if_l4.clear_errors = 1'b0;
        checks++; if (if_l4.underflow !== 1'b0) begin failures++; $display("[TB] FAIL t4_clear: got %b expected 0", if_l4.underflow); end
    endtask

    // Registered read data: one-cycle valid pulse, data held afterwards
    task automatic test_registered_read();
        if_r4.data_in = 8'h11; if_r4.write_en = 1'b1; tick(); if_r4.write_en = 1'b0; tick();
        if_r4.data_in = 8'h22; if_r4.write_en = 1'b1; tick(); if_r4.write_en = 1'b0; tick();
        checks++; if (if_r4.data_valid !== 1'b0 || if_r4.data_out !== 8'h00 || if_r4.level !== 3'd2) begin failures++; $display("[TB] FAIL t5_pre: got valid=%b dout=%h level=%0d expected 0 00 2", if_r4.data_valid, if_r4.data_out, if_r4.level); end
        if_r4.read_en = 1'b1;
        tick();
        if_r4.read_en = 1'b0;
        checks++; if (if_r4.data_valid !== 1'b1 || if_r4.data_out !== 8'h11) begin failures++; $display("[TB] FAIL t5_pulse: got valid=%b dout=%h expected 1 11", if_r4.data_valid, if_r4.data_out); end
        tick();
        checks++; if (if_r4.data_valid !== 1'b0 || if_r4.data_out !== 8'h11 || if_r4.level !== 3'd1) begin failures++; $display("[TB] FAIL t5_hold: got valid=%b dout=%h level=%0d expected 0 11 1", if_r4.data_valid, if_r4.data_out, if_r4.level); end
        tick();
        checks++; if (if_r4.data_out !== 8'h11) begin failures++; $display("[TB] FAIL t5_hold2: got %h expected 11", if_r4.data_out); end
        if_r4.read_en = 1'b1;
        tick();
        if_r4.read_en = 1'b0;
        checks++; if (if_r4.data_valid !== 1'b1 || if_r4.data_out !== 8'h22 || if_r4.empty !== 1'b1) begin failures++; $display("[TB] FAIL t5_second: got valid=%b dout=%h empty=%b expected 1 22 1", if_r4.data_valid, if_r4.data_out, if_r4.empty); end
        tick();
    endtask

    // Threshold flags on the way up, reset at level 9, refill across the wrap
    task automatic test_thresholds_and_reset();
        logic [7:0] q[$];
        logic [7:0] d;
        int         lvl;
        for (lvl = 1; lvl <= 9; lvl++) begin
            if_d16.data_in = 8'($urandom);
            if_d16.write_en = 1'b1;
            tick();
            checks++; if (if_d16.level !== 5'(lvl) || if_d16.almost_empty !== (lvl <= 2) || if_d16.almost_full !== (lvl >= 14) || if_d16.empty !== 1'b0) begin failures++; $display("[TB] FAIL t6_fill%0d: got level=%0d ae=%b af=%b expected level=%0d ae=%b af=%b", lvl, if_d16.level, if_d16.almost_empty, if_d16.almost_full, lvl, (lvl <= 2), (lvl >= 14)); end
        end
        rst_d16 = 1'b1;
        tick();
        rst_d16 = 1'b0;
        if_d16.write_en = 1'b0;
        checks++; if (if_d16.level !== 5'd0 || if_d16.empty !== 1'b1 || if_d16.full !== 1'b0 || if_d16.almost_full !== 1'b0 || if_d16.almost_empty !== 1'b1) begin failures++; $display("[TB] FAIL t6_reset: got level=%0d empty=%b full=%b af=%b ae=%b expected 0 1 0 0 1", if_d16.level, if_d16.empty, if_d16.full, if_d16.almost_full, if_d16.almost_empty); end
        checks++; if (if_d16.overflow !== 1'b0 || if_d16.underflow !== 1'b0 || if_d16.data_valid !== 1'b0) begin failures++; $display("[TB] FAIL t6_reset_err: got ovf=%b unf=%b valid=%b expected 0 0 0", if_d16.overflow, if_d16.underflow, if_d16.data_valid); end
        tick();
        // refill to full, pop five, push five more so the write side wraps
        for (lvl = 1; lvl <= 16; lvl++) begin
            d = 8'($urandom);
            q.push_back(d);
            if_d16.data_in = d;
            if_d16.write_en = 1'b1;
            tick();
            checks++; if (if_d16.level !== 5'(lvl) || if_d16.almost_empty !== (lvl <= 2) || if_d16.almost_full !== (lvl >= 14) || if_d16.full !== (lvl == 16)) begin failures++; $display("[TB] FAIL t6_refill%0d: got level=%0d ae=%b af=%b full=%b", lvl, if_d16.level, if_d16.almost_empty, if_d16.almost_full, if_d16.full); end
        end
        if_d16.write_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (if_d16.data_out !== q[0]) begin failures++; $display("[TB] FAIL t6_pop%0d: got %h expected %h", i, if_d16.data_out, q[0]); end
            void'(q.pop_front());
            if_d16.read_en = 1'b1;
            tick();
        end
        if_d16.read_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            q.push_back(d);
            if_d16.data_in = d;
            if_d16.write_en = 1'b1;
            tick();
        end
        if_d16.write_en = 1'b0;
        checks++; if (if_d16.full !== 1'b1 || if_d16.overflow !== 1'b0) begin failures++; $display("[TB] FAIL t6_wrapfull: got full=%b ovf=%b expected 1 0", if_d16.full, if_d16.overflow); end
        while (q.size() > 0) begin
            checks++; if (if_d16.data_out !== q[0]) begin failures++; $display("[TB] FAIL t6_drain: got %h expected %h", if_d16.data_out, q[0]); end
            void'(q.pop_front());
            if_d16.read_en = 1'b1;
            tick();
        end
        if_d16.read_en = 1'b0;
        checks++; if (if_d16.empty !== 1'b1 || if_d16.underflow !== 1'b0) begin failures++; $display("[TB] FAIL t6_end: got empty=%b unf=%b expected 1 0", if_d16.empty, if_d16.underflow); end
    endtask

    // Random level-mode traffic on the depth-16 FIFO against a queue model
    task automatic test_random_level();
        logic [7:0] q[$];
        bit         ovf = 1'b0;
        bit         unf = 1'b0;
        bit         wr, rd, clr, rd_ok, wr_ok;
        logic [7:0] d;
        int         n;
        for (int c = 0; c < 600; c++) begin
            wr  = ($urandom_range(0, 99) < (((c / 60) % 2 == 0) ? 75 : 30));
            rd  = ($urandom_range(0, 99) < (((c / 60) % 2 == 0) ? 30 : 75));
            clr = ($urandom_range(0, 15) == 0);
            d   = 8'($urandom);
            if_d16.write_en = wr; if_d16.read_en = rd; if_d16.clear_errors = clr; if_d16.data_in = d;
            rd_ok = rd && (q.size() > 0);
            wr_ok = wr && ((q.size() < 16) || rd_ok);
            if (rd_ok) void'(q.pop_front());
            if (wr_ok) q.push_back(d);
            if (wr && !wr_ok) ovf = 1'b1; else if (clr) ovf = 1'b0;
            if (rd && !rd_ok) unf = 1'b1; else if (clr) unf = 1'b0;
            tick();
            n = q.size();
            checks++; if (if_d16.level !== 5'(n)) begin failures++; $display("[TB] FAIL rl_level c=%0d: got %0d expected %0d", c, if_d16.level, n); end
            checks++; if ({if_d16.full, if_d16.empty, if_d16.almost_full, if_d16.almost_empty, if_d16.overflow, if_d16.underflow, if_d16.data_valid} !== {n == 16, n == 0, n >= 14, n <= 2, ovf, unf, n != 0}) begin failures++; $display("[TB] FAIL rl_flags c=%0d: got %b expected %b", c, {if_d16.full, if_d16.empty, if_d16.almost_full, if_d16.almost_empty, if_d16.overflow, if_d16.underflow, if_d16.data_valid}, {n == 16, n == 0, n >= 14, n <= 2, ovf, unf, n != 0}); end
            if (n > 0) begin
                checks++; if (if_d16.data_out !== q[0]) begin failures++; $display("[TB] FAIL rl_data c=%0d: got %h expected %h", c, if_d16.data_out, q[0]); end
            end
        end
        if_d16.write_en = 1'b0; if_d16.read_en = 1'b0; if_d16.clear_errors = 1'b0;
        tick();
    endtask

    // Random edge-mode traffic on the registered-read FIFO against a queue model
    task automatic test_random_edge_registered();
        logic [7:0] q[$];
        logic [7:0] exp_dout = 8'h22;
        bit         ovf = 1'b0;
        bit         unf = 1'b0;
        bit         prev_wr = 1'b0;
        bit         prev_rd = 1'b0;
        bit         wr, rd, clr, wr_req, rd_req, rd_ok, wr_ok;
        logic [7:0] d;
        int         n;
        for (int c = 0; c < 400; c++) begin
            wr  = ($urandom_range(0, 99) < (((c / 50) % 2 == 0) ? 70 : 35));
            rd  = ($urandom_range(0, 99) < (((c / 50) % 2 == 0) ? 35 : 70));
            clr = ($urandom_range(0, 11) == 0);
            d   = 8'($urandom);
            if_r4.write_en = wr; if_r4.read_en = rd; if_r4.clear_errors = clr; if_r4.data_in = d;
            wr_req = wr && !prev_wr;
            rd_req = rd && !prev_rd;
            prev_wr = wr;
            prev_rd = rd;
            rd_ok = rd_req && (q.size() > 0);
            wr_ok = wr_req && ((q.size() < 4) || rd_ok);
            if (rd_ok) exp_dout = q.pop_front();
            if (wr_ok) q.push_back(d);
            if (wr_req && !wr_ok) ovf = 1'b1; else if (clr) ovf = 1'b0;
            if (rd_req && !rd_ok) unf = 1'b1; else if (clr) unf = 1'b0;
            tick();
            n = q.size();
            checks++; if (if_r4.level !== 3'(n)) begin failures++; $display("[TB] FAIL re_level c=%0d: got %0d expected %0d", c, if_r4.level, n); end
            checks++; if ({if_r4.full, if_r4.empty, if_r4.almost_full, if_r4.almost_empty, if_r4.overflow, if_r4.underflow, if_r4.data_valid} !== {n == 4, n == 0, n >= 3, n == 0, ovf, unf, rd_ok}) begin failures++; $display("[TB] FAIL re_flags c=%0d: got %b expected %b", c, {if_r4.full, if_r4.empty, if_r4.almost_full, if_r4.almost_empty, if_r4.overflow, if_r4.underflow, if_r4.data_valid}, {n == 4, n == 0, n >= 3, n == 0, ovf, unf, rd_ok}); end
            checks++; if (if_r4.data_out !== exp_dout) begin failures++; $display("[TB] FAIL re_data c=%0d: got %h expected %h", c, if_r4.data_out, exp_dout); end
        end
        if_r4.write_en = 1'b0; if_r4.read_en = 1'b0; if_r4.clear_errors = 1'b0;
        tick();
    endtask

    // Drive idle inputs, then run every scenario in order
    initial begin
        if_e4.write_en = 1'b0;  if_e4.read_en = 1'b0;  if_e4.clear_errors = 1'b0;  if_e4.data_in = 8'h00;
        if_l4.write_en = 1'b0;  if_l4.read_en = 1'b0;  if_l4.clear_errors = 1'b0;  if_l4.data_in = 8'h00;
        if_r4.write_en = 1'b0;  if_r4.read_en = 1'b0;  if_r4.clear_errors = 1'b0;  if_r4.data_in = 8'h00;
        if_d16.write_en = 1'b0; if_d16.read_en = 1'b0; if_d16.clear_errors = 1'b0; if_d16.data_in = 8'h00;
        rst_e4 = 1'b1; rst_l4 = 1'b1; rst_r4 = 1'b1; rst_d16 = 1'b1;

        $display("[TB] starting fifo_sync_flags bench");
        test_reset();
        test_overflow_edge();
        test_edge_hold();
        test_push_pop_full();
        test_push_pop_empty();
        test_registered_read();
        test_thresholds_and_reset();
        test_random_level();
        test_random_edge_registered();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
Parametrised synchronous single-clock FIFO. It is the successor to the team's basic edge-triggered FIFO.
- Adds a selectable request mode (edge or level).
- Adds a selectable read mode (first-word-fall-through or registered).
- Supports simultaneous push/pop when full.
- Adds programmable almost-full/almost-empty flags, a fill-level output, and sticky overflow/underflow error flags.
- Sits between host-side command/UART logic and LED/peripheral drivers on the Tang Nano 20K.

Parameters:
DATA_WIDTH, 8, width of each entry
DEPTH, 16, number of entries; power of two, >= 2
EDGE_MODE, 1, 1 = one operation per rising edge of write_en/read_en; 0 = one operation per cycle while high
FWFT, 1, 1 = head entry visible on data_out without a read; 0 = data_out registered, valid one cycle after an accepted read
AFULL_THRESH, DEPTH-2, almost_full asserted when level >= AFULL_THRESH
AEMPTY_THRESH, 2, almost_empty asserted when level <= AEMPTY_THRESH

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
write_en  in  1  write request (edge- or level-qualified per EDGE_MODE)
read_en  in  1  read request (edge- or level-qualified per EDGE_MODE)
data_in  in  DATA_WIDTH  write data, sampled on accepted write
clear_errors  in  1  clears overflow/underflow
data_out  out  DATA_WIDTH  read data
data_valid  out  1  FWFT=1: equals !empty; FWFT=0: one-cycle pulse when data_out updated
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AFULL_THRESH
almost_empty  out  1  level <= AEMPTY_THRESH
level  out  $clog2(DEPTH)+1  current number of stored entries
overflow  out  1  sticky: write request dropped
underflow  out  1  sticky: read request on empty

Behaviour:
- Reset (synchronous, dominates all other inputs): wr_ptr=0, rd_ptr=0, level=0, request-delay regs=0, overflow=0, underflow=0, data_out=0 (FWFT=0 only), data_valid=0. The resulting outputs are empty=1, full=0, almost_empty=1, and almost_full=(AFULL_THRESH==0). Memory contents are not reset.
- Reset mid-operation discards all contents. The next cycle behaves as a fresh FIFO.
- Request qualification:
  - EDGE_MODE=1: wr_req = write_en & ~write_en_d, and likewise rd_req.
  - Delay regs clear on reset, so an enable held high through reset yields one request on the first cycle after reset.
  - EDGE_MODE=0: wr_req = write_en, rd_req = read_en.
- Acceptance:
  - rd_acc = rd_req & !empty.
  - wr_acc = wr_req & (!full | rd_acc). A write while full is accepted when a read is accepted in the same cycle.
  - A read on empty is never accepted, even with a simultaneous write. The written word is stored and readable next cycle.
- wr_acc: mem[wr_ptr] <= data_in; wr_ptr increments. rd_acc: rd_ptr increments.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- level: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither. level never exceeds DEPTH or goes below 0.
- All flags are combinational from registered level (zero-latency relative to level).
- FWFT=1: data_out = mem[rd_ptr] combinationally. Contents are undefined when empty. The first written word appears the cycle after wr_acc.
- FWFT=0:
  - On rd_acc, data_out <= mem[rd_ptr] and data_valid pulses high for exactly one cycle.
  - data_out holds otherwise.
  - Read latency is 1 cycle.
- overflow set when wr_req & !wr_acc. underflow set when rd_req & !rd_acc.
- Both flags hold until clear_errors. If set and clear occur in the same cycle, set wins.
- DEPTH not a power of two, or a threshold outside 0..DEPTH, is a configuration error and must be flagged by a simulation-time check.

Decomposition:
- Shared include fifo_defs.vh holds the mode constants: EDGE_MODE_LEVEL=0, EDGE_MODE_EDGE=1, FWFT_OFF=0, FWFT_ON=1.
- One sub-module: fifo_req_qual. It takes en and outputs req. It has an EDGE_MODE parameter and a synchronous delay reg, and is instantiated twice (write and read).

Test Plan:
1. DEPTH=4, EDGE_MODE=1, FWFT=1: push 0xA1..0xA4 as 1-cycle pulses, then a 5th push of 0xA5. Required: full=1, level=4, overflow=1, data_out=0xA1. Pop four times and read 0xA1..0xA4 in order; then empty=1, and overflow stays 1 until clear_errors.
2. EDGE_MODE=1: hold write_en high for 5 cycles with data 0x55. Required: level=1 only, no overflow.
3. EDGE_MODE=0, DEPTH=4, FIFO full: assert write_en and read_en together for 1 cycle with data 0x77. Required: level stays 4, no overflow, and 0x77 is the 4th word out.
4. Empty FIFO, EDGE_MODE=0: simultaneous write of 0x3C and read in one cycle. Required: underflow=1, level=1 next cycle, and the next read returns 0x3C.
5. FWFT=0: push 0x11, 0x22, then pop. Required: data_valid is a 1-cycle pulse one cycle after the pop with data_out=0x11, and data_out holds 0x11 afterwards.
6. DEPTH=16, AFULL=14, AEMPTY=2: fill one word at a time, with reset asserted when level=9. Required:
   - almost_empty=1 for levels 0..2.
   - almost_full=1 at level 14.
   - After the reset at level 9, the next cycle shows level=0, empty=1, flags=0, and the wr_ptr wrap is exercised after refill.
